// File: rtl/imem_fetch.sv
// Byte-addressed instruction memory for the IF stage: runtime byte loads, a
// sequential clear after reset, and a registered multi-byte fetch with range faults.
module imem_fetch #(
    parameter int DEPTH       = 32,
    parameter int AW          = 16,
    parameter int FETCH_BYTES = 2,
    parameter int WRAP        = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AW-1:0]            pc,
    input  logic                     fetch_req,
    output logic                     fetch_ready,
    output logic [8*FETCH_BYTES-1:0] inst,
    output logic                     inst_valid,
    input  logic                     inst_stall,
    output logic                     fault,
    input  logic                     ld_en,
    input  logic [AW-1:0]            ld_addr,
    input  logic [7:0]               ld_data,
    output logic                     busy
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    // Handshake: a fetch is accepted on any edge where fetch_req && fetch_ready;
    // the result appears one edge later and is held while inst_valid && inst_stall.

    state_t                   state_q;
    logic [IW-1:0]            clr_cnt_q;
    logic [8*FETCH_BYTES-1:0] inst_q, inst_d;
    logic                     inst_valid_q;
    logic                     fault_q, fault_d;
    logic [AW:0]              end_addr;
    logic                     ld_in_range;
    logic [7:0]               mem_q [DEPTH];

    function automatic logic [IW-1:0] byte_idx(input logic [AW:0] a);
        return IW'(a % DEPTH_W);
    endfunction

    // Range check is done one bit wider than pc so addresses near 2^AW cannot alias.
    assign end_addr    = {1'b0, pc} + (AW+1)'(FETCH_BYTES - 1);
    assign ld_in_range = ({1'b0, ld_addr} < DEPTH_W);

    always_comb begin
        fault_d = (WRAP == 0) && (end_addr >= DEPTH_W);
        inst_d  = '0;
        if (!fault_d) begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
                inst_d[8*(FETCH_BYTES-1-k) +: 8] = mem_q[byte_idx({1'b0, pc} + (AW+1)'(k))];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_IDX) begin
                        state_q <= READY;
                    end
                end
                READY: begin
                    if (inst_valid_q && inst_stall) begin
                        inst_valid_q <= 1'b1;
                    end else if (fetch_req) begin
                        inst_q       <= inst_d;
                        inst_valid_q <= 1'b1;
                        fault_q      <= fault_d;
                    end else begin
                        inst_valid_q <= 1'b0;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    // Storage has no reset; the clear engine and the load port share one write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[clr_cnt_q] <= 8'h00;
            end else if (ld_en && ld_in_range) begin
                mem_q[IW'(ld_addr)] <= ld_data;
            end
        end
    end

    assign fetch_ready = (state_q == READY) && !(inst_valid_q && inst_stall);
    assign busy        = (state_q == CLEAR);
    assign inst        = inst_q;
    assign inst_valid  = inst_valid_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: one WRAP=0 and one WRAP=1 instance share all
// inputs; expected values are hand-computed per step.
module tb_imem_fetch;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc;
    logic          fetch_req;
    logic          inst_stall;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;

    logic          fetch_ready, inst_valid, fault, busy;
    logic [15:0]   inst;
    logic          w_fetch_ready, w_inst_valid, w_fault, w_busy;
    logic [15:0]   w_inst;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imem_fetch #(.DEPTH(32), .AW(AW), .FETCH_BYTES(2), .WRAP(0)) u_dut (
        .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req),
        .fetch_ready(fetch_ready), .inst(inst), .inst_valid(inst_valid),
        .inst_stall(inst_stall), .fault(fault), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
    );

    imem_fetch #(.DEPTH(32), .AW(AW), .FETCH_BYTES(2), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req),
        .fetch_ready(w_fetch_ready), .inst(w_inst), .inst_valid(w_inst_valid),
        .inst_stall(inst_stall), .fault(w_fault), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data), .busy(w_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        fetch_req = 1'b1; pc = a;
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic check_clear_window(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk({tag, "_busy"}, {28'd0, busy, fetch_ready, inst_valid, w_busy}, 32'b1001);
            chk({tag, "_inst"}, {16'd0, inst}, 32'h0);
            tick();
        end
        chk({tag, "_done"}, {30'd0, busy, fetch_ready}, 32'b01);
    endtask

    initial begin
        rst = 1'b0; pc = '0; fetch_req = 1'b0; inst_stall = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        tick();

        // 1: reset pulse, clear window; fetches and loads during clear are ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fetch_req = 1'b1; pc = 16'd2;
        ld_en = 1'b1; ld_addr = 16'd3; ld_data = 8'h77;
        check_clear_window("t1_clear");
        fetch_req = 1'b0; ld_en = 1'b0;
        fetch(16'd2);
        chk("t1_fetch_inst", {16'd0, inst}, 32'h0000);
        chk("t1_fetch_flags", {30'd0, inst_valid, fault}, 32'b10);
        tick();
        chk("t1_idle_valid", {31'd0, inst_valid}, 32'd0);
        chk("t1_idle_hold", {16'd0, inst}, 32'h0000);

        // 2: loads then fetches; an out-of-range load is dropped
        load(16'd0, 8'h01);
        load(16'd1, 8'h2F);
        load(16'd5, 8'h4C);
        load(16'd40, 8'hFF);
        fetch(16'd0);
        chk("t2_pc0_inst", {16'd0, inst}, 32'h012F);
        chk("t2_pc0_flags", {30'd0, inst_valid, fault}, 32'b10);
        fetch(16'd4);
        chk("t2_pc4_inst", {16'd0, inst}, 32'h004C);
        fetch(16'd8);
        chk("t2_oor_load", {16'd0, inst}, 32'h0000);

        // 3: boundary fetches, WRAP=0 faults vs WRAP=1 wraparound
        load(16'd31, 8'hAB);
        fetch(16'd30);
        chk("t3_pc30_inst", {16'd0, inst}, 32'h00AB);
        chk("t3_pc30_fault", {31'd0, fault}, 32'd0);
        fetch(16'd31);
        chk("t3_pc31_inst", {16'd0, inst}, 32'h0000);
        chk("t3_pc31_flags", {30'd0, inst_valid, fault}, 32'b11);
        chk("t3_wrap31_inst", {16'd0, w_inst}, 32'hAB01);
        chk("t3_wrap31_flags", {30'd0, w_inst_valid, w_fault}, 32'b10);
        fetch(16'hFFFF);
        chk("t3_pcmax_fault", {31'd0, fault}, 32'd1);
        chk("t3_wrapmax_inst", {16'd0, w_inst}, 32'hAB01);

        // 4: stall holds result; load accepted while stalled
        fetch(16'd0);
        chk("t4_pre_inst", {16'd0, inst}, 32'h012F);
        inst_stall = 1'b1; fetch_req = 1'b1; pc = 16'd4;
        #1;
        chk("t4_ready_low", {31'd0, fetch_ready}, 32'd0);
        ld_en = 1'b1; ld_addr = 16'd10; ld_data = 8'h66;
        for (int i = 0; i < 3; i++) begin
            tick();
            ld_en = 1'b0;
            chk("t4_stall_inst", {16'd0, inst}, 32'h012F);
            chk("t4_stall_flags", {29'd0, inst_valid, fault, fetch_ready}, 32'b100);
        end
        inst_stall = 1'b0;
        tick();
        fetch_req = 1'b0;
        chk("t4_release_inst", {16'd0, inst}, 32'h004C);
        fetch(16'd10);
        chk("t4_stall_load", {16'd0, inst}, 32'h6600);

        // 5: reset mid-clear restarts the counter and clears loaded bytes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t5_midclear_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_clear_window("t5_clear");
        fetch(16'd0);
        chk("t5_pc0_cleared", {16'd0, inst}, 32'h0000);
        fetch(16'd4);
        chk("t5_pc4_cleared", {16'd0, inst}, 32'h0000);
        fetch(16'd30);
        chk("t5_pc30_cleared", {16'd0, inst}, 32'h0000);

        // 6: simultaneous load and fetch is read-before-write
        ld_en = 1'b1; ld_addr = 16'd4; ld_data = 8'h55;
        fetch(16'd4);
        ld_en = 1'b0;
        chk("t6_rbw_inst", {16'd0, inst}, 32'h0000);
        fetch(16'd4);
        chk("t6_after_inst", {16'd0, inst}, 32'h5500);
        chk("t6_after_wrap", {16'd0, w_inst}, 32'h5500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
